// File: rtl/rv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rv_pipe_pkg
// Shared types and constants for the in-order pipeline stages.
//   ctrl_t       : decoded control bundle carried from ID into EX
//   CTRL_NOP     : all-zero control bundle, used for bubbles
//   ALU_OP_*     : encodings of ctrl_t.alu_op
//   idex_act_e   : per-edge action selected by the ID/EX register
//   ctrl_gate()  : passes a control bundle only for a real instruction
// ---------------------------------------------------------------------------
package rv_pipe_pkg;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   localparam logic [1:0] ALU_OP_ADD    = 2'b00; // address / plain add
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01; // compare for branch
   localparam logic [1:0] ALU_OP_RTYPE  = 2'b10; // decode funct3/funct7
   localparam logic [1:0] ALU_OP_ITYPE  = 2'b11; // decode funct3 only

   // Action applied to the ID/EX register on the next rising edge.
   typedef enum logic [1:0] {
      ACT_LOAD   = 2'b00,
      ACT_HOLD   = 2'b01,
      ACT_BUBBLE = 2'b10
   } idex_act_e;

   // A non-instruction must never carry live control into EX.
   function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic valid);
      ctrl_t r;
      if (valid) begin
         r = c;
      end else begin
         r = CTRL_NOP;
      end
      return r;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard compare. Flags when the instruction in ID
// reads a register that the load currently in EX will write; the load data
// is only available after MEM, so one bubble is required.
// Ports:
//   ex_valid_i     : EX holds a real instruction
//   ex_mem_read_i  : instruction in EX is a load
//   ex_rd_i        : destination register of the instruction in EX
//   id_valid_i     : ID holds a real instruction
//   id_rs1_i/rs2_i : ID source register addresses
//   id_uses_rs1_i/id_uses_rs2_i : ID instruction actually reads that source
//   load_use_o     : hazard present this cycle
// ---------------------------------------------------------------------------
module load_use_detect #(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid_i,
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_uses_rs1_i,
   input  logic              id_uses_rs2_i,
   output logic              load_use_o
);

   logic w_ex_load;
   logic w_rs1_hit;
   logic w_rs2_hit;

   // x0 is hard-wired zero, so a load into x0 never creates a dependency.
   assign w_ex_load = ex_valid_i & ex_mem_read_i & (ex_rd_i != {REG_AW{1'b0}});

   // Address matches only count for operands the instruction really reads.
   assign w_rs1_hit = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
   assign w_rs2_hit = id_uses_rs2_i & (id_rs2_i == ex_rd_i);

   assign load_use_o = w_ex_load & id_valid_i & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_reg
// ID/EX pipeline register with integrated load-use hazard detection.
// Captures operands, register addresses, funct fields and control from ID
// every cycle and presents them to the EX stage one cycle later. A
// load-use hazard turns the next edge into a single bubble and raises
// stall_o so PC and IF/ID hold; flush_i kills the stage; hold_i freezes it.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush_i, hold_i       : branch flush, downstream freeze
//   id_*_i                : decoded instruction from the ID stage
//   stall_o               : combinational stall request towards PC / IF/ID
//   id_ex_*_o             : registered copies consumed by EX/forwarding
//   load_use_cnt_o        : saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_pipeline_reg
   import rv_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              hold_i,
   input  logic              id_valid_i,
   input  logic [XLEN-1:0]   id_pc_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_uses_rs1_i,
   input  logic              id_uses_rs2_i,
   input  logic [2:0]        id_funct3_i,
   input  logic              id_funct7b5_i,
   input  ctrl_t             id_ctrl_i,
   output logic              stall_o,
   output logic              id_ex_valid_o,
   output logic [XLEN-1:0]   id_ex_pc_o,
   output logic [XLEN-1:0]   id_ex_rs1_data_o,
   output logic [XLEN-1:0]   id_ex_rs2_data_o,
   output logic [XLEN-1:0]   id_ex_imm_o,
   output logic [REG_AW-1:0] id_ex_rs1_o,
   output logic [REG_AW-1:0] id_ex_rs2_o,
   output logic [REG_AW-1:0] id_ex_rd_o,
   output logic [2:0]        id_ex_funct3_o,
   output logic              id_ex_funct7b5_o,
   output ctrl_t             id_ex_ctrl_o,
   output logic [CNT_W-1:0]  load_use_cnt_o
);

   // Counter stops at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

   // ---------------- state ----------------
   logic              r_valid;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_rs1_data;
   logic [XLEN-1:0]   r_rs2_data;
   logic [XLEN-1:0]   r_imm;
   logic [REG_AW-1:0] r_rs1;
   logic [REG_AW-1:0] r_rs2;
   logic [REG_AW-1:0] r_rd;
   logic [2:0]        r_funct3;
   logic              r_funct7b5;
   ctrl_t             r_ctrl;
   logic [CNT_W-1:0]  r_cnt;

   // ---------------- next-state ----------------
   logic              w_valid_nxt;
   logic [XLEN-1:0]   w_pc_nxt;
   logic [XLEN-1:0]   w_rs1_data_nxt;
   logic [XLEN-1:0]   w_rs2_data_nxt;
   logic [XLEN-1:0]   w_imm_nxt;
   logic [REG_AW-1:0] w_rs1_nxt;
   logic [REG_AW-1:0] w_rs2_nxt;
   logic [REG_AW-1:0] w_rd_nxt;
   logic [2:0]        w_funct3_nxt;
   logic              w_funct7b5_nxt;
   ctrl_t             w_ctrl_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;

   logic              w_load_use;
   logic              w_cnt_inc;
   idex_act_e         w_act;

   load_use_detect #(
      .REG_AW (REG_AW)
   ) u_load_use_detect (
      .ex_valid_i    (r_valid),
      .ex_mem_read_i (r_ctrl.mem_read),
      .ex_rd_i       (r_rd),
      .id_valid_i    (id_valid_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_uses_rs1_i (id_uses_rs1_i),
      .id_uses_rs2_i (id_uses_rs2_i),
      .load_use_o    (w_load_use)
   );

   // A flush already discards the ID instruction, so there is nothing to stall.
   assign stall_o = (w_load_use | hold_i) & ~flush_i;

   // Select the edge action: flush beats hold beats load-use beats normal load.
   always_comb begin
      w_act     = ACT_LOAD;
      w_cnt_inc = 1'b0;
      if (flush_i) begin
         w_act = ACT_BUBBLE;
      end else if (hold_i) begin
         w_act = ACT_HOLD;
      end else if (w_load_use) begin
         w_act     = ACT_BUBBLE;
         w_cnt_inc = 1'b1;
      end else begin
         w_act = ACT_LOAD;
      end
   end

   // Build next register contents for the selected action.
   always_comb begin
      w_valid_nxt    = r_valid;
      w_pc_nxt       = r_pc;
      w_rs1_data_nxt = r_rs1_data;
      w_rs2_data_nxt = r_rs2_data;
      w_imm_nxt      = r_imm;
      w_rs1_nxt      = r_rs1;
      w_rs2_nxt      = r_rs2;
      w_rd_nxt       = r_rd;
      w_funct3_nxt   = r_funct3;
      w_funct7b5_nxt = r_funct7b5;
      w_ctrl_nxt     = r_ctrl;
      w_cnt_nxt      = r_cnt;

      case (w_act)
         ACT_LOAD: begin
            w_valid_nxt    = id_valid_i;
            w_pc_nxt       = id_pc_i;
            w_rs1_data_nxt = id_rs1_data_i;
            w_rs2_data_nxt = id_rs2_data_i;
            w_imm_nxt      = id_imm_i;
            w_rs1_nxt      = id_rs1_i;
            w_rs2_nxt      = id_rs2_i;
            w_funct3_nxt   = id_funct3_i;
            w_funct7b5_nxt = id_funct7b5_i;
            // A non-instruction must not write back or match forwarding.
            w_ctrl_nxt     = ctrl_gate(id_ctrl_i, id_valid_i);
            if (id_valid_i) begin
               w_rd_nxt = id_rd_i;
            end else begin
               w_rd_nxt = {REG_AW{1'b0}};
            end
         end
         ACT_HOLD: begin
            w_valid_nxt = r_valid;
         end
         ACT_BUBBLE: begin
            // Register addresses cleared so forwarding never matches a bubble;
            // datapath fields are left as-is since nothing consumes them.
            w_valid_nxt = 1'b0;
            w_ctrl_nxt  = CTRL_NOP;
            w_rd_nxt    = {REG_AW{1'b0}};
            w_rs1_nxt   = {REG_AW{1'b0}};
            w_rs2_nxt   = {REG_AW{1'b0}};
            if (w_cnt_inc) begin
               w_cnt_nxt = sat_inc(r_cnt);
            end else begin
               w_cnt_nxt = r_cnt;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_ctrl_nxt  = CTRL_NOP;
            w_rd_nxt    = {REG_AW{1'b0}};
            w_rs1_nxt   = {REG_AW{1'b0}};
            w_rs2_nxt   = {REG_AW{1'b0}};
         end
      endcase
   end

   // ID/EX state register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_pc       <= {XLEN{1'b0}};
         r_rs1_data <= {XLEN{1'b0}};
         r_rs2_data <= {XLEN{1'b0}};
         r_imm      <= {XLEN{1'b0}};
         r_rs1      <= {REG_AW{1'b0}};
         r_rs2      <= {REG_AW{1'b0}};
         r_rd       <= {REG_AW{1'b0}};
         r_funct3   <= 3'b000;
         r_funct7b5 <= 1'b0;
         r_ctrl     <= CTRL_NOP;
         r_cnt      <= {CNT_W{1'b0}};
      end else begin
         r_valid    <= w_valid_nxt;
         r_pc       <= w_pc_nxt;
         r_rs1_data <= w_rs1_data_nxt;
         r_rs2_data <= w_rs2_data_nxt;
         r_imm      <= w_imm_nxt;
         r_rs1      <= w_rs1_nxt;
         r_rs2      <= w_rs2_nxt;
         r_rd       <= w_rd_nxt;
         r_funct3   <= w_funct3_nxt;
         r_funct7b5 <= w_funct7b5_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_cnt      <= w_cnt_nxt;
      end
   end

   assign id_ex_valid_o    = r_valid;
   assign id_ex_pc_o       = r_pc;
   assign id_ex_rs1_data_o = r_rs1_data;
   assign id_ex_rs2_data_o = r_rs2_data;
   assign id_ex_imm_o      = r_imm;
   assign id_ex_rs1_o      = r_rs1;
   assign id_ex_rs2_o      = r_rs2;
   assign id_ex_rd_o       = r_rd;
   assign id_ex_funct3_o   = r_funct3;
   assign id_ex_funct7b5_o = r_funct7b5;
   assign id_ex_ctrl_o     = r_ctrl;
   assign load_use_cnt_o   = r_cnt;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipeline_reg
// Directed bench for id_ex_pipeline_reg (CNT_W=4 so saturation is reachable).
// ---------------------------------------------------------------------------
module tb_id_ex_pipeline_reg;
   import rv_pipe_pkg::*;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   // control encodings: ALU r-type, load, lui
   localparam ctrl_t C_ALU  = 8'h84;
   localparam ctrl_t C_LOAD = 8'hD8;
   localparam ctrl_t C_LUI  = 8'h8E;

   logic              clk;
   logic              rst_n;
   logic              flush_i;
   logic              hold_i;
   logic              id_valid_i;
   logic [XLEN-1:0]   id_pc_i;
   logic [XLEN-1:0]   id_rs1_data_i;
   logic [XLEN-1:0]   id_rs2_data_i;
   logic [XLEN-1:0]   id_imm_i;
   logic [REG_AW-1:0] id_rs1_i;
   logic [REG_AW-1:0] id_rs2_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_uses_rs1_i;
   logic              id_uses_rs2_i;
   logic [2:0]        id_funct3_i;
   logic              id_funct7b5_i;
   ctrl_t             id_ctrl_i;
   logic              stall_o;
   logic              id_ex_valid_o;
   logic [XLEN-1:0]   id_ex_pc_o;
   logic [XLEN-1:0]   id_ex_rs1_data_o;
   logic [XLEN-1:0]   id_ex_rs2_data_o;
   logic [XLEN-1:0]   id_ex_imm_o;
   logic [REG_AW-1:0] id_ex_rs1_o;
   logic [REG_AW-1:0] id_ex_rs2_o;
   logic [REG_AW-1:0] id_ex_rd_o;
   logic [2:0]        id_ex_funct3_o;
   logic              id_ex_funct7b5_o;
   ctrl_t             id_ex_ctrl_o;
   logic [CNT_W-1:0]  load_use_cnt_o;

   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt;

   id_ex_pipeline_reg #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW),
      .CNT_W  (CNT_W)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush_i          (flush_i),
      .hold_i           (hold_i),
      .id_valid_i       (id_valid_i),
      .id_pc_i          (id_pc_i),
      .id_rs1_data_i    (id_rs1_data_i),
      .id_rs2_data_i    (id_rs2_data_i),
      .id_imm_i         (id_imm_i),
      .id_rs1_i         (id_rs1_i),
      .id_rs2_i         (id_rs2_i),
      .id_rd_i          (id_rd_i),
      .id_uses_rs1_i    (id_uses_rs1_i),
      .id_uses_rs2_i    (id_uses_rs2_i),
      .id_funct3_i      (id_funct3_i),
      .id_funct7b5_i    (id_funct7b5_i),
      .id_ctrl_i        (id_ctrl_i),
      .stall_o          (stall_o),
      .id_ex_valid_o    (id_ex_valid_o),
      .id_ex_pc_o       (id_ex_pc_o),
      .id_ex_rs1_data_o (id_ex_rs1_data_o),
      .id_ex_rs2_data_o (id_ex_rs2_data_o),
      .id_ex_imm_o      (id_ex_imm_o),
      .id_ex_rs1_o      (id_ex_rs1_o),
      .id_ex_rs2_o      (id_ex_rs2_o),
      .id_ex_rd_o       (id_ex_rd_o),
      .id_ex_funct3_o   (id_ex_funct3_o),
      .id_ex_funct7b5_o (id_ex_funct7b5_o),
      .id_ex_ctrl_o     (id_ex_ctrl_o),
      .load_use_cnt_o   (load_use_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic [2:0] f3,
                        input logic f7, input ctrl_t c);
      id_valid_i    = v;
      id_pc_i       = pc;
      id_rs1_data_i = d1;
      id_rs2_data_i = d2;
      id_imm_i      = imm;
      id_rs1_i      = rs1;
      id_rs2_i      = rs2;
      id_rd_i       = rd;
      id_uses_rs1_i = u1;
      id_uses_rs2_i = u2;
      id_funct3_i   = f3;
      id_funct7b5_i = f7;
      id_ctrl_i     = c;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      flush_i = 1'b0;
      hold_i  = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, CTRL_NOP);
      #2;
      // reset state
      chk("rst_valid", 64'(id_ex_valid_o), 64'd0);
      chk("rst_ctrl",  64'(id_ex_ctrl_o),  64'd0);
      chk("rst_cnt",   64'(load_use_cnt_o), 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);
      step();
      rst_n = 1'b1;

      // id_valid_i=0: fields load, ctrl and rd forced to zero
      drive(1'b0, 32'h200, 32'h1, 32'h2, 32'h3, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 3'd1, 1'b0, C_ALU);
      step();
      chk("inv_valid", 64'(id_ex_valid_o), 64'd0);
      chk("inv_pc",    64'(id_ex_pc_o), 64'h200);
      chk("inv_rs1",   64'(id_ex_rs1_o), 64'd3);
      chk("inv_rd",    64'(id_ex_rd_o), 64'd0);
      chk("inv_ctrl",  64'(id_ex_ctrl_o), 64'd0);

      // add x5,x1,x2
      drive(1'b1, 32'h100, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 3'd0, 1'b0, C_ALU);
      chk("add_stall", 64'(stall_o), 64'd0);
      step();
      chk("add_valid", 64'(id_ex_valid_o), 64'd1);
      chk("add_pc",    64'(id_ex_pc_o), 64'h100);
      chk("add_d1",    64'(id_ex_rs1_data_o), 64'h11);
      chk("add_d2",    64'(id_ex_rs2_data_o), 64'h22);
      chk("add_rd",    64'(id_ex_rd_o), 64'd5);
      chk("add_ctrl",  64'(id_ex_ctrl_o), 64'(C_ALU));

      // sub x6,x5,x3 back to back: no stall
      drive(1'b1, 32'h104, 32'h33, 32'h44, 32'h0, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1, 3'd0, 1'b1, C_ALU);
      chk("sub_stall", 64'(stall_o), 64'd0);
      step();
      chk("sub_pc",  64'(id_ex_pc_o), 64'h104);
      chk("sub_rs1", 64'(id_ex_rs1_o), 64'd5);
      chk("sub_rd",  64'(id_ex_rd_o), 64'd6);
      chk("sub_f7",  64'(id_ex_funct7b5_o), 64'd1);

      // lw x5,8(x1) then add x7,x5,x1
      drive(1'b1, 32'h108, 32'h55, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 3'd2, 1'b0, C_LOAD);
      chk("lw_stall", 64'(stall_o), 64'd0);
      step();
      chk("lw_ctrl", 64'(id_ex_ctrl_o), 64'(C_LOAD));
      drive(1'b1, 32'h10C, 32'hAA, 32'hBB, 32'h0, 5'd5, 5'd1, 5'd7, 1'b1, 1'b1, 3'd0, 1'b0, C_ALU);
      chk("lu_stall", 64'(stall_o), 64'd1);
      step();
      chk("lu_bub_valid", 64'(id_ex_valid_o), 64'd0);
      chk("lu_bub_rd",    64'(id_ex_rd_o), 64'd0);
      chk("lu_bub_rs1",   64'(id_ex_rs1_o), 64'd0);
      chk("lu_bub_ctrl",  64'(id_ex_ctrl_o), 64'd0);
      chk("lu_bub_pc",    64'(id_ex_pc_o), 64'h108);
      chk("lu_bub_imm",   64'(id_ex_imm_o), 64'h8);
      chk("lu_cnt",       64'(load_use_cnt_o), 64'd1);
      chk("lu_stall2",    64'(stall_o), 64'd0);
      step();
      chk("lu_add_valid", 64'(id_ex_valid_o), 64'd1);
      chk("lu_add_pc",    64'(id_ex_pc_o), 64'h10C);
      chk("lu_add_rd",    64'(id_ex_rd_o), 64'd7);
      chk("lu_add_d1",    64'(id_ex_rs1_data_o), 64'hAA);

      // lw x0 then add x8,x0,x0: no hazard
      drive(1'b1, 32'h110, 32'h0, 32'h0, 32'h4, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 3'd2, 1'b0, C_LOAD);
      step();
      drive(1'b1, 32'h114, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 3'd0, 1'b0, C_ALU);
      chk("x0_stall", 64'(stall_o), 64'd0);
      step();
      chk("x0_pc", 64'(id_ex_pc_o), 64'h114);
      chk("x0_rd", 64'(id_ex_rd_o), 64'd8);

      // lw x5 then lui x5 (reads no sources): no hazard
      drive(1'b1, 32'h118, 32'h0, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 3'd2, 1'b0, C_LOAD);
      step();
      drive(1'b1, 32'h11C, 32'h0, 32'h0, 32'h12345000, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 3'd0, 1'b0, C_LUI);
      chk("lui_stall", 64'(stall_o), 64'd0);
      step();
      chk("lui_pc",   64'(id_ex_pc_o), 64'h11C);
      chk("lui_ctrl", 64'(id_ex_ctrl_o), 64'(C_LUI));
      chk("lui_cnt",  64'(load_use_cnt_o), 64'd1);

      // flush + hold + load-use all at once
      drive(1'b1, 32'h120, 32'h0, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 3'd2, 1'b0, C_LOAD);
      step();
      flush_i = 1'b1;
      hold_i  = 1'b1;
      drive(1'b1, 32'h124, 32'h0, 32'h0, 32'h0, 5'd5, 5'd1, 5'd7, 1'b1, 1'b1, 3'd0, 1'b0, C_ALU);
      chk("fl_stall", 64'(stall_o), 64'd0);
      step();
      chk("fl_valid", 64'(id_ex_valid_o), 64'd0);
      chk("fl_rd",    64'(id_ex_rd_o), 64'd0);
      chk("fl_ctrl",  64'(id_ex_ctrl_o), 64'd0);
      chk("fl_pc",    64'(id_ex_pc_o), 64'h120);
      chk("fl_cnt",   64'(load_use_cnt_o), 64'd1);
      flush_i = 1'b0;
      hold_i  = 1'b0;

      // hold for 3 cycles during a load-use hazard
      drive(1'b1, 32'h128, 32'h0, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 3'd2, 1'b0, C_LOAD);
      step();
      hold_i = 1'b1;
      drive(1'b1, 32'h12C, 32'h0, 32'h0, 32'h0, 5'd5, 5'd1, 5'd7, 1'b1, 1'b1, 3'd0, 1'b0, C_ALU);
      for (int i = 0; i < 3; i++) begin
         chk("hold_stall", 64'(stall_o), 64'd1);
         step();
         chk("hold_pc",   64'(id_ex_pc_o), 64'h128);
         chk("hold_ctrl", 64'(id_ex_ctrl_o), 64'(C_LOAD));
         chk("hold_cnt",  64'(load_use_cnt_o), 64'd1);
      end
      hold_i = 1'b0;
      #1;
      chk("rel_stall", 64'(stall_o), 64'd1);
      step();
      chk("rel_valid", 64'(id_ex_valid_o), 64'd0);
      chk("rel_cnt",   64'(load_use_cnt_o), 64'd2);
      step();
      chk("rel_pc",    64'(id_ex_pc_o), 64'h12C);
      chk("rel_rd",    64'(id_ex_rd_o), 64'd7);

      // drive counter into saturation (4-bit counter)
      exp_cnt = 2;
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 32'h300, 32'h0, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 3'd2, 1'b0, C_LOAD);
         step();
         drive(1'b1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd7, 1'b1, 1'b1, 3'd0, 1'b0, C_ALU);
         step();
         exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
         chk("sat_cnt", 64'(load_use_cnt_o), 64'(exp_cnt));
         step();
      end
      chk("sat_final", 64'(load_use_cnt_o), 64'hF);

      // reset while a load-use stall is pending
      drive(1'b1, 32'h130, 32'h0, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 3'd2, 1'b0, C_LOAD);
      step();
      drive(1'b1, 32'h134, 32'h0, 32'h0, 32'h0, 5'd5, 5'd1, 5'd7, 1'b1, 1'b1, 3'd0, 1'b0, C_ALU);
      chk("mr_stall_pre", 64'(stall_o), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_valid", 64'(id_ex_valid_o), 64'd0);
      chk("mr_pc",    64'(id_ex_pc_o), 64'd0);
      chk("mr_rd",    64'(id_ex_rd_o), 64'd0);
      chk("mr_ctrl",  64'(id_ex_ctrl_o), 64'd0);
      chk("mr_cnt",   64'(load_use_cnt_o), 64'd0);
      chk("mr_stall", 64'(stall_o), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_pc",  64'(id_ex_pc_o), 64'h134);
      chk("post_cnt", 64'(load_use_cnt_o), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
